// File: rtl/compressor_layer_sched_pkg.sv
// Shared definitions for the layer scheduler: FSM encoding, bitwidth port sizing, mask helper.
// No logic of its own; imported by the table, the interface and the top.
// Helpers are constant functions so they can size ports and parameters.
package compressor_layer_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_SKIP  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_FIN   = 3'd6
  } state_e;

  // Width of a bitwidth field able to hold the value MAXBITWIDTH itself.
  function automatic int bw_w(input int maxbw);
    return $clog2(maxbw) + 1;
  endfunction

  // Mask with the low 'bw' bits set; saturates to all ones at 32 and above.
  function automatic logic [31:0] mask_of(input logic [31:0] bw);
    if (bw >= 32'd32) return '1;
    return (32'd1 << bw) - 32'd1;
  endfunction

endpackage

// File: rtl/compressor_layer_sched_if.sv
// Stream and static-config bundle between upstream source, scheduler and one compressor.
// Pure wiring, no latency.
// Valid/ready on the value stream; trm_* are observed only, never back-pressured here.
interface compressor_layer_sched_if
  import compressor_layer_sched_pkg::*;
#(
  parameter int MAXBITWIDTH = 16
) ();

  localparam int BW_W = bw_w(MAXBITWIDTH);

  logic                   src_valid;
  logic [MAXBITWIDTH-1:0] src_data;
  logic                   src_ready;
  logic                   cmp_rstn;
  logic [MAXBITWIDTH-1:0] cmp_mask_valid_bits;
  logic [BW_W-1:0]        cmp_bitwidth_d;
  logic [31:0]            cmp_num_of_output_values;
  logic                   cmp_rcv_valid;
  logic [MAXBITWIDTH-1:0] cmp_rcv_data;
  logic                   cmp_rcv_ready;
  logic                   cmp_trm_valid;
  logic                   cmp_trm_last;
  logic                   cmp_trm_ready;

  // Scheduler side.
  modport master (
    input  src_valid, src_data, cmp_rcv_ready,
    input  cmp_trm_valid, cmp_trm_last, cmp_trm_ready,
    output src_ready, cmp_rstn, cmp_mask_valid_bits, cmp_bitwidth_d,
    output cmp_num_of_output_values, cmp_rcv_valid, cmp_rcv_data
  );

  // Source plus compressor side.
  modport slave (
    output src_valid, src_data, cmp_rcv_ready,
    output cmp_trm_valid, cmp_trm_last, cmp_trm_ready,
    input  src_ready, cmp_rstn, cmp_mask_valid_bits, cmp_bitwidth_d,
    input  cmp_num_of_output_values, cmp_rcv_valid, cmp_rcv_data
  );

endinterface

// File: rtl/compressor_layer_sched_cfg_table.sv
// Per-layer configuration register file: (bitwidth, value count) per entry.
// Write takes effect at the next clock edge; read is combinational.
// No backpressure; writes are accepted every cycle.
module compressor_cfg_table
  import compressor_layer_sched_pkg::*;
#(
  parameter int MAXBITWIDTH = 16,
  parameter int MAX_LAYERS  = 16,
  parameter int LAYER_IDX_W = $clog2(MAX_LAYERS)
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [LAYER_IDX_W-1:0]        wr_addr,
  input  logic [bw_w(MAXBITWIDTH)-1:0]  wr_bitwidth,
  input  logic [31:0]                   wr_count,
  input  logic [LAYER_IDX_W-1:0]        rd_addr,
  output logic [bw_w(MAXBITWIDTH)-1:0]  rd_bitwidth,
  output logic [31:0]                   rd_count
);

  logic [bw_w(MAXBITWIDTH)-1:0] bw_mem  [MAX_LAYERS];
  logic [31:0]                  cnt_mem [MAX_LAYERS];

  // Table contents are deliberately left unreset; software loads them before start.
  always_ff @(posedge clk) begin
    if (we) begin
      bw_mem[wr_addr]  <= wr_bitwidth;
      cnt_mem[wr_addr] <= wr_count;
    end
  end

  assign rd_bitwidth = bw_mem[rd_addr];
  assign rd_count    = cnt_mem[rd_addr];

endmodule

// File: rtl/compressor_layer_sched.sv
// Walks the layer table, loads each layer's config into the compressor and meters its input stream.
// Start to first input opportunity is 2+CLEAR_CYCLES cycles; done arrives the cycle after FIN.
// Stream is a combinational pass-through during RUN, closed once the layer's count has been accepted.
module compressor_layer_sched
  import compressor_layer_sched_pkg::*;
#(
  parameter int MAXBITWIDTH  = 16,
  parameter int MAX_LAYERS   = 16,
  parameter int CLEAR_CYCLES = 2,
  parameter int LAYER_IDX_W  = $clog2(MAX_LAYERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [LAYER_IDX_W-1:0]        cfg_addr,
  input  logic [bw_w(MAXBITWIDTH)-1:0]  cfg_bitwidth,
  input  logic [31:0]                   cfg_count,
  input  logic [LAYER_IDX_W:0]          num_layers,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          layer_done,
  output logic [LAYER_IDX_W-1:0]        layer_idx,
  output logic                          cfg_err,
  compressor_layer_sched_if.master      bus
);

  localparam int BW_W = bw_w(MAXBITWIDTH);

  state_e                 state_q, state_d;
  logic [LAYER_IDX_W:0]   num_q;
  logic [LAYER_IDX_W:0]   idx_nxt;
  logic [3:0]             clr_cnt_q;
  logic [31:0]            acc_q;
  logic [BW_W-1:0]        tbl_bw;
  logic [31:0]            tbl_cnt;
  logic                   rstn_q;
  logic [MAXBITWIDTH-1:0] mask_q;
  logic [BW_W-1:0]        bw_q;
  logic [31:0]            cnt_q;
  logic                   bw_bad, last_layer, at_count, trm_end;
  logic                   run_open, rcv_valid_c, src_ready_c, rcv_fire;

  compressor_cfg_table #(
    .MAXBITWIDTH (MAXBITWIDTH),
    .MAX_LAYERS  (MAX_LAYERS),
    .LAYER_IDX_W (LAYER_IDX_W)
  ) u_table (
    .clk         (clk),
    .we          (cfg_we),
    .wr_addr     (cfg_addr),
    .wr_bitwidth (cfg_bitwidth),
    .wr_count    (cfg_count),
    .rd_addr     (layer_idx),
    .rd_bitwidth (tbl_bw),
    .rd_count    (tbl_cnt)
  );

  assign bw_bad     = (tbl_bw == '0) || (int'(tbl_bw) > MAXBITWIDTH);
  assign idx_nxt    = {1'b0, layer_idx} + (LAYER_IDX_W+1)'(1);
  assign last_layer = (idx_nxt == num_q);
  assign at_count   = (acc_q == cnt_q);
  assign trm_end    = bus.cmp_trm_valid && bus.cmp_trm_last && bus.cmp_trm_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_layers == '0) ? ST_FIN : ST_LOAD;
      ST_LOAD:  state_d = (bw_bad || tbl_cnt == 32'd0) ? ST_SKIP : ST_CLEAR;
      ST_CLEAR: if (clr_cnt_q == 4'd0) state_d = ST_RUN;
      ST_RUN:   if (trm_end) state_d = ST_NEXT;
      ST_SKIP:  state_d = ST_NEXT;
      ST_NEXT:  state_d = last_layer ? ST_FIN : ST_LOAD;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stream gate: open only in RUN and only until the layer's count has been taken.
  always_comb begin
    run_open    = (state_q == ST_RUN) && !at_count;
    rcv_valid_c = run_open && bus.src_valid;
    src_ready_c = run_open && bus.cmp_rcv_ready;
    rcv_fire    = rcv_valid_c && bus.cmp_rcv_ready;
  end

  // Registered status, per-layer config and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      layer_done <= 1'b0;
      layer_idx  <= '0;
      cfg_err    <= 1'b0;
      num_q      <= '0;
      clr_cnt_q  <= '0;
      acc_q      <= '0;
      rstn_q     <= 1'b0;
      mask_q     <= '0;
      bw_q       <= '0;
      cnt_q      <= '0;
    end else begin
      busy       <= (state_d != ST_IDLE);
      done       <= (state_q == ST_FIN);
      layer_done <= (state_q == ST_NEXT);
      case (state_q)
        ST_IDLE: if (start) begin
          num_q     <= num_layers;
          cfg_err   <= 1'b0;
          layer_idx <= '0;
        end
        ST_LOAD: begin
          bw_q      <= tbl_bw;
          mask_q    <= MAXBITWIDTH'(mask_of(32'(tbl_bw)));
          cnt_q     <= tbl_cnt;
          acc_q     <= '0;
          clr_cnt_q <= 4'(CLEAR_CYCLES - 1);
          if (bw_bad) cfg_err <= 1'b1;
        end
        ST_CLEAR: if (clr_cnt_q != 4'd0) clr_cnt_q <= clr_cnt_q - 4'd1;
        ST_RUN:   if (rcv_fire) acc_q <= acc_q + 32'd1;
        ST_NEXT:  if (!last_layer) layer_idx <= idx_nxt[LAYER_IDX_W-1:0];
        default: ;
      endcase
      // Compressor stays out of reset through NEXT/LOAD/SKIP so the reset window is exactly CLEAR.
      case (state_d)
        ST_RUN:                     rstn_q <= 1'b1;
        ST_CLEAR, ST_FIN, ST_IDLE:  rstn_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.cmp_rstn                 = rstn_q;
  assign bus.cmp_mask_valid_bits      = mask_q;
  assign bus.cmp_bitwidth_d           = bw_q;
  assign bus.cmp_num_of_output_values = cnt_q;
  assign bus.cmp_rcv_valid            = rcv_valid_c;
  assign bus.cmp_rcv_data             = bus.src_data;
  assign bus.src_ready                = src_ready_c;

endmodule

// File: doc/compressor_layer_sched.md
Name: compressor_layer_sched

Overview:
- Sequences the 16-bit stacking compressor across a network's layers.
- Holds a per-layer configuration table (bitwidth, value count) and loads it onto the compressor's static inputs for each layer.
- Clears the compressor between layers and gates the upstream value stream so only the configured number of values reaches it.
- Detects end-of-layer from the compressor's trm_last and advances to the next layer; sits between the DMA/config master and one compressor instance.

Parameters:
- MAXBITWIDTH, 16, input value width; compressor bitwidth limit.
- MAX_LAYERS, 16, number of configuration table entries.
- CLEAR_CYCLES, 2, cycles the compressor reset is held low between layers (range 1..15).
- LAYER_IDX_W, $clog2(MAX_LAYERS), width of layer index/address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  LAYER_IDX_W  table entry index.
- cfg_bitwidth  in  $clog2(MAXBITWIDTH)+1  layer bitwidth.
- cfg_count  in  32  layer output value count.
- num_layers  in  LAYER_IDX_W+1  layers to run (0..MAX_LAYERS), sampled at start.
- start  in  1  single-cycle start pulse; ignored unless idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last layer.
- layer_done  out  1  one-cycle pulse per finished or skipped layer.
- layer_idx  out  LAYER_IDX_W  current layer.
- cfg_err  out  1  sticky; set when a layer bitwidth is invalid; cleared by start.
- cmp_rstn  out  1  active-low reset to the compressor.
- cmp_mask_valid_bits  out  MAXBITWIDTH  mask with bitwidth LSBs set.
- cmp_bitwidth_d  out  $clog2(MAXBITWIDTH)+1  to compressor.
- cmp_num_of_output_values  out  32  to compressor.
- src_valid  in  1  upstream value valid.
- src_data  in  MAXBITWIDTH  upstream value.
- src_ready  out  1  upstream accept.
- cmp_rcv_valid  out  1  to compressor.
- cmp_rcv_data  out  MAXBITWIDTH  to compressor.
- cmp_rcv_ready  in  1  from compressor.
- cmp_trm_valid  in  1  compressor output valid; monitored only.
- cmp_trm_last  in  1  compressor output last; monitored only.
- cmp_trm_ready  in  1  downstream ready; monitored only.

Behaviour:
- Reset values: busy=0, done=0, layer_done=0, layer_idx=0, cfg_err=0, cmp_rstn=0, cmp_mask_valid_bits=0, cmp_bitwidth_d=0, cmp_num_of_output_values=0, src_ready=0, cmp_rcv_valid=0. Table contents are not reset.
- Table writes are accepted in any state. A write to the current layer's entry while RUN is active takes effect only on the next load.
- FSM states:
  - IDLE: cmp_rstn=0. On start, latch num_layers, clear cfg_err, set layer_idx=0. If num_layers==0, go to FIN; otherwise go to LOAD.
  - LOAD (1 cycle): register cmp_bitwidth_d, cmp_mask_valid_bits=(1<<bw)-1 and cmp_num_of_output_values from the table. If bw==0 or bw>MAXBITWIDTH: set cfg_err and go to SKIP. If count==0: go to SKIP. Otherwise go to CLEAR with the clear counter set to CLEAR_CYCLES.
  - CLEAR: cmp_rstn=0; decrement the counter. At 0, release cmp_rstn=1 and go to RUN.
  - RUN: combinational pass-through cmp_rcv_valid=src_valid, cmp_rcv_data=src_data, src_ready=cmp_rcv_ready. Increment the accepted counter on src_valid&&cmp_rcv_ready. When accepted==count, force cmp_rcv_valid=0 and src_ready=0. Exit on cmp_trm_valid&&cmp_trm_last&&cmp_trm_ready, going to NEXT.
  - SKIP: no compressor activity; go to NEXT.
  - NEXT (1 cycle): pulse layer_done. If layer_idx+1==latched num_layers, go to FIN; otherwise increment layer_idx and go to LOAD.
  - FIN (1 cycle): pulse done, drop busy, assert cmp_rstn=0, go to IDLE.
- busy=1 in every state except IDLE.
- Minimum latency from start to first cmp_rcv_valid opportunity: 2+CLEAR_CYCLES cycles.
- An end-of-layer event seen in the same cycle as the final accept: the accepted count still increments, then the block exits to NEXT.
- rst asserted mid-layer: everything returns to reset values on the next edge, cmp_rstn=0, and the stream is dropped.
- start while busy: ignored.
- The accepted counter is 32-bit and is compared with ==. Wrap-around is impossible because gating stops at count.

Decomposition:
- Shared package/definitions header holds:
  - FSM state encodings (IDLE, LOAD, CLEAR, RUN, SKIP, NEXT, FIN);
  - the bitwidth port width expression;
  - the mask-generation function.
- One sub-module: compressor_cfg_table, an MAX_LAYERS x (bw, count) register file with one write port and an asynchronous read port indexed by layer_idx.

Test Plan:
- 2 layers, {bw=4, count=8} then {bw=8, count=4}, with a compressor model: cmp_mask_valid_bits reads 0x000F then 0x00FF; exactly 8 then 4 accepts; two layer_done pulses; done pulses once.
- Layer 1 has bw=0, layer 2 is {bw=5, count=3}: cfg_err=1; layer 1 skipped with no cmp_rcv_valid; layer 2 runs; done pulses.
- CLEAR_CYCLES=3: cmp_rstn is low for exactly 3 cycles after LOAD, and the first cmp_rcv_valid appears 5 cycles after start.
- src_valid held high past count=6: the 7th value is not accepted (src_ready=0) until the next layer's RUN.
- rst asserted during RUN of layer 1 of 3: next cycle busy=0, cmp_rstn=0, layer_idx=0. A subsequent start runs all 3 layers.
- num_layers=0: done pulses 2 cycles after start, with cmp_rstn never released.
